// File: rtl/mips_dmem_responder.sv
// Word-wide data-memory responder with valid/ready request and response channels
// and a fixed number of wait states. Define DMEM_ERR_EN to flag misaligned or zero-enable requests.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          flag_q, flag_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word, wr_word, be_mask;
  logic          mem_we, accept, req_flag;

`ifdef DMEM_ERR_EN
  logic unused_addr;
  assign req_flag    = (req_addr[1:0] != 2'b00) || (req_write && (req_be == 4'b0000));
  assign unused_addr = ^req_addr[31:AW+2];
`else
  logic unused_addr;
  assign req_flag    = 1'b0;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign accept    = req_valid && (state_q == S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign rd_word = mem[idx_q];
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign wr_word = (rd_word & ~be_mask) | (wdata_q & be_mask);
  // Flagged requests run the full timing but never commit to memory.
  assign mem_we  = (state_q == S_ACCESS) && write_q && !flag_q;

  always_comb begin
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    flag_d  = flag_q;
    if (accept) begin
      idx_d   = req_addr[AW+1:2];
      write_d = req_write;
      wdata_d = req_wdata;
      be_d    = req_be;
      flag_d  = req_flag;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_rdata_d = (write_q || flag_q) ? 32'd0 : rd_word;
        rsp_err_d   = flag_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d   = S_IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Latched request fields carry data only; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    flag_q  <= flag_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wr_word;
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: random and directed loads/stores checked
// against a word-array memory model, with latency, stability and reset checks.
module tb_mips_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;
  localparam int IW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference behaviour: one outstanding request, so the model updates at issue time.
  task automatic model_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be);
    exp_t e;
    int   i;
    i = int'(addr[IW+1:2]);
    e.rdata = 32'd0;
    e.err   = 1'b0;
`ifdef DMEM_ERR_EN
    if (addr[1:0] != 2'b00 || (wr && be == 4'b0000)) begin
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
`endif
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
    end else begin
      e.rdata = ref_mem[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit use_model);
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    #1;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!req_ready) begin
      fail("req_ready_wait");
      req_valid = 1'b0;
      return;
    end
    if (use_model) model_req(wr, addr, wd, be);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || rsp_valid) fail(name);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 1)      rsp_ready = 1'b0;
      else if (rdy_mode == 2) rsp_ready = 1'b1;
      else                    rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples mid-low-phase, after drivers have settled for the coming edge.
  initial begin
    bit          prev_v = 1'b0;
    bit          prev_hs = 1'b0;
    logic [31:0] hold_rdata = 32'd0;
    logic        hold_err = 1'b0;
    exp_t        e;
    int          a;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        acc_q.delete();
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (prev_hs) chk("idle_after_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
        if (rsp_valid) begin
          if (!prev_v) begin
            if (acc_q.size() == 0) begin
              fail("rsp_without_accept");
            end else begin
              a = acc_q.pop_front();
              chk("latency", 32'(cyc - a), 32'(W + 2));
            end
            hold_rdata = rsp_rdata;
            hold_err   = rsp_err;
          end else begin
            chk("rdata_stable", rsp_rdata, hold_rdata);
            chk("err_stable", {31'd0, rsp_err}, {31'd0, hold_err});
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
          end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              fail("unexpected_rsp");
            end else begin
              e = exp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
          end
        end
        prev_hs = rsp_valid && rsp_ready;
        prev_v  = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), 32'd0, 4'hF, 1'b1);
    wait_idle("drain_init");

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
    issue(1'b0, 32'h20, 32'd0, 4'h0, 1'b1);
    issue(1'b1, 32'h400, 32'h5, 4'hF, 1'b1);
    issue(1'b0, 32'h0, 32'd0, 4'h0, 1'b1);
`ifdef DMEM_ERR_EN
    issue(1'b0, 32'h6, 32'd0, 4'h0, 1'b1);
    issue(1'b1, 32'h40, 32'h12345678, 4'h0, 1'b1);
    issue(1'b0, 32'h40, 32'd0, 4'h0, 1'b1);
`else
    issue(1'b1, 32'h40, 32'h12345678, 4'h0, 1'b1);
    issue(1'b0, 32'h43, 32'd0, 4'h0, 1'b1);
`endif
    wait_idle("drain_directed");

    rdy_mode = 1;
    issue(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid) fail("hold_rsp_wait");
    repeat (5) @(negedge clk);
    rdy_mode = 2;
    wait_idle("drain_hold");
    rdy_mode = 0;

    issue(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    issue(1'b0, 32'h8, 32'd0, 4'h0, 1'b1);
    wait_idle("drain_reset");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[31:6] = 26'd0;
      issue(1'($urandom), ad, $urandom, 4'($urandom), 1'b1);
    end
    wait_idle("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Data-memory responder for the MIPS core's load/store port: accepts one word request at a time over a valid/ready handshake, performs the byte-enabled write or the word read after a programmable number of wait states, and returns a response over a second valid/ready handshake. It sits between the core's load/store path and the data RAM. It replaces the zero-latency combinational memory once the core moves to a stallable memory interface.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 2: wait states inserted before the access; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored on loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores.
- rsp_err  out  1  error response (only with DMEM_ERR_EN).

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready = 1. A request is accepted on an edge where req_valid && req_ready. On acceptance, latch req_write, req_addr, req_wdata and req_be. Go to WAIT with the counter at WAIT_CYCLES-1, or go directly to ACCESS if WAIT_CYCLES == 0.
- WAIT: count down. At 0, go to ACCESS. Request inputs are ignored.
- ACCESS: one cycle.
  - Store: write the enabled bytes of the latched data to word mem[addr[log2(DEPTH_WORDS)+1:2]], and load 0 into rsp_rdata.
  - Load: load the full word into rsp_rdata.
  - Go to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready is sampled high. On that edge, clear rsp_valid and go to IDLE.
- req_ready is 1 only in IDLE, so at most one request is outstanding. There is no back-to-back overlap with a response.
- Address bits above the index range are ignored: the address wraps modulo DEPTH_WORDS*4.
- A store with req_be = 4'b0000 completes normally and leaves memory unchanged (without DMEM_ERR_EN).
- Memory contents are not reset. The simulation model initialises all words to 0.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- Latency: if the request is accepted at edge E0, rsp_valid rises after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES = 0: rsp_valid rises after E1.
  - WAIT_CYCLES = 2: rsp_valid rises after E3.
- Store commit: memory is updated on the ACCESS edge, i.e. the same edge that raises rsp_valid.
- rsp_ready high before rsp_valid rises has no effect.
- If rsp_ready is high in the first RESP cycle, the response lasts exactly one cycle. IDLE (req_ready = 1) follows on the next cycle.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- rst_n low at any point returns all state and outputs to reset values immediately.
  - A store not yet past ACCESS is dropped with no memory change.
  - A pending response is discarded.

## Configuration
- Macro: DMEM_ERR_EN.
- Defined:
  - A request is flagged at acceptance if req_addr[1:0] != 0, or if it is a store with req_be == 0.
  - A flagged request goes through the normal WAIT/ACCESS/RESP timing but does not touch memory.
  - Its response carries rsp_err = 1 and rsp_rdata = 0.
  - rsp_err is cleared with rsp_valid.
- Not defined:
  - rsp_err is tied to 0.
  - req_addr[1:0] is ignored; the access is forced word-aligned.
  - A zero-enable store is a no-op with a normal response.

## Test plan
- WAIT_CYCLES = 2. Store 0xDEADBEEF to 0x10 with be = 4'hF, then load 0x10 -> rsp_rdata = 0xDEADBEEF; rsp_valid rises exactly 3 edges after each acceptance.
- Store 0x11223344 to 0x20 with be = 4'hF, then store 0xAABBCCDD with be = 4'b0101, then load -> rsp_rdata = 0x11BB33DD.
- Hold rsp_ready low for 5 cycles during RESP -> rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready -> IDLE on the next cycle.
- DEPTH_WORDS = 256. Store 0x5 to 0x400, then load 0x0 -> rsp_rdata = 0x5 (address wrap).
- Assert rst_n low during WAIT of a store of 0xFFFFFFFF to 0x8 -> outputs at reset values, no response. A following load of 0x8 returns the prior value 0.
- With DMEM_ERR_EN: load 0x6 -> rsp_err = 1, rsp_rdata = 0, memory unchanged. Store with be = 0 -> rsp_err = 1.
